shared_ll_fifo: RTL

SHARED_LL_FIFO -- requirements
Module: shared_ll_fifo

---
 rtl/shared_ll_fifo_if.sv | 33 +++
 rtl/shared_ll_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/shared_ll_fifo_if.sv
// Request/response bundle for shared_ll_fifo: push/pop handshake plus per-queue status.
// The master modport is the user side, the slave modport is the FIFO side.
interface shared_ll_fifo_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 4
);
    localparam int SEL_WIDTH = $clog2(NUM_FIFOS);
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    logic                           push;
    logic [SEL_WIDTH-1:0]           push_sel;
    logic [WIDTH-1:0]               data_in;
    logic                           pop;
    logic [SEL_WIDTH-1:0]           pop_sel;
    logic [WIDTH-1:0]               data_out;
    logic [NUM_FIFOS-1:0]           empty;
    logic [NUM_FIFOS-1:0]           full;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0]           free_count;
    logic                           push_err;
    logic                           pop_err;

    modport master (
        output push, push_sel, data_in, pop, pop_sel,
        input  data_out, empty, full, count, free_count, push_err, pop_err
    );

    modport slave (
        input  push, push_sel, data_in, pop, pop_sel,
        output data_out, empty, full, count, free_count, push_err, pop_err
    );
endinterface

// File: rtl/shared_ll_fifo.sv
// NUM_FIFOS logical queues sharing one DEPTH-entry linked-list store, with RESERVE
// entries guaranteed per queue and the remainder handed out first-come from a shared pool.
module shared_ll_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 4,
    parameter int RESERVE   = 1
) (
    input  logic            clk,
    input  logic            rst,
    shared_ll_fifo_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int SEL_WIDTH = $clog2(NUM_FIFOS);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int SUM_W     = CNT_WIDTH + SEL_WIDTH;
    localparam int SHARED    = DEPTH - NUM_FIFOS * RESERVE;

    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] RES_C    = CNT_WIDTH'(RESERVE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [SUM_W-1:0]     SHARED_S = SUM_W'(SHARED);
    localparam logic [SUM_W-1:0]     DEPTH_S  = SUM_W'(DEPTH);

    logic [WIDTH-1:0]     r_data [DEPTH];
    logic [PTR_WIDTH-1:0] r_next [DEPTH];
    logic [PTR_WIDTH-1:0] r_head [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] r_tail [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] r_cnt  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] r_free_head;
    logic [PTR_WIDTH-1:0] r_free_tail;
    logic                 r_push_err;
    logic                 r_pop_err;

    logic [SUM_W-1:0]               w_shared_used;
    logic [SUM_W-1:0]               w_total;
    logic [CNT_WIDTH-1:0]           w_free_cnt;
    logic [NUM_FIFOS-1:0]           w_empty;
    logic [NUM_FIFOS-1:0]           w_full;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] w_count;
    logic                           w_push_ok;
    logic                           w_pop_ok;
    logic                           w_same;
    logic [PTR_WIDTH-1:0]           w_alloc;
    logic [PTR_WIDTH-1:0]           w_pop_ent;

    always_comb begin
        w_shared_used = '0;
        w_total       = '0;
        w_count       = '0;
        for (int j = 0; j < NUM_FIFOS; j++) begin
            w_total = w_total + SUM_W'(r_cnt[j]);
            if (r_cnt[j] > RES_C)
                w_shared_used = w_shared_used + SUM_W'(r_cnt[j] - RES_C);
            w_count[j*CNT_WIDTH +: CNT_WIDTH] = r_cnt[j];
        end
    end

    // A queue below its reservation can always accept; above it, only while the pool lasts.
    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_flag
        assign w_empty[g] = (r_cnt[g] == '0);
        assign w_full[g]  = (r_cnt[g] == DEPTH_C) ||
                            ((r_cnt[g] >= RES_C) && (w_shared_used == SHARED_S));
    end

    assign w_free_cnt = CNT_WIDTH'(DEPTH_S - w_total);
    assign w_push_ok  = bus.push & ~w_full[bus.push_sel];
    assign w_pop_ok   = bus.pop  & ~w_empty[bus.pop_sel];
    assign w_same     = (bus.push_sel == bus.pop_sel);
    assign w_alloc    = r_free_head;
    assign w_pop_ent  = r_head[bus.pop_sel];

    assign bus.data_out   = w_empty[bus.pop_sel] ? '0 : r_data[w_pop_ent];
    assign bus.empty      = w_empty;
    assign bus.full       = w_full;
    assign bus.count      = w_count;
    assign bus.free_count = w_free_cnt;
    assign bus.push_err   = r_push_err;
    assign bus.pop_err    = r_pop_err;

    // Payload store is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_data[w_alloc] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                r_head[i] <= '0;
                r_tail[i] <= '0;
                r_cnt[i]  <= '0;
            end
            for (int i = 0; i < DEPTH; i++)
                r_next[i] <= PTR_WIDTH'(i + 1);
            r_free_head <= '0;
            r_free_tail <= PTR_WIDTH'(DEPTH - 1);
            r_push_err  <= 1'b0;
            r_pop_err   <= 1'b0;
        end else begin
            r_push_err <= bus.push & ~w_push_ok;
            r_pop_err  <= bus.pop  & ~w_pop_ok;

            // Queue links
            if (w_push_ok && w_pop_ok && w_same) begin
                if (r_cnt[bus.pop_sel] == CNT_ONE) begin
                    r_head[bus.pop_sel] <= w_alloc;
                end else begin
                    r_head[bus.pop_sel]           <= r_next[w_pop_ent];
                    r_next[r_tail[bus.push_sel]] <= w_alloc;
                end
                r_tail[bus.push_sel] <= w_alloc;
            end else begin
                if (w_push_ok) begin
                    if (w_empty[bus.push_sel])
                        r_head[bus.push_sel] <= w_alloc;
                    else
                        r_next[r_tail[bus.push_sel]] <= w_alloc;
                    r_tail[bus.push_sel] <= w_alloc;
                    r_cnt[bus.push_sel]  <= r_cnt[bus.push_sel] + CNT_ONE;
                end
                if (w_pop_ok) begin
                    r_head[bus.pop_sel] <= r_next[w_pop_ent];
                    r_cnt[bus.pop_sel]  <= r_cnt[bus.pop_sel] - CNT_ONE;
                end
            end

            // Free list: a popped entry joins the tail and is only reachable next cycle.
            // When the list would otherwise drain to nothing, the popped entry becomes the whole list.
            if (w_pop_ok) begin
                r_free_tail <= w_pop_ent;
                if (w_free_cnt == (w_push_ok ? CNT_ONE : '0)) begin
                    r_free_head <= w_pop_ent;
                end else begin
                    r_next[r_free_tail] <= w_pop_ent;
                    if (w_push_ok)
                        r_free_head <= r_next[r_free_head];
                end
            end else if (w_push_ok) begin
                r_free_head <= r_next[r_free_head];
            end
        end
    end
endmodule
